// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine holding the HI/LO registers.
// One result bit is produced per cycle on operand magnitudes; signs are fixed up in a final cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q, neg_d;
    logic                 rem_neg_q, rem_neg_d;
    logic                 dz_q, dz_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opd_q, opd_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 div_zero_q, div_zero_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

    // Datapath helpers: operand magnitudes, shift-add sum, restoring trial subtract and sign fix-up.
    always_comb begin
        mag_a    = (func[0] && a[WIDTH-1]) ? -a : a;
        mag_b    = (func[0] && b[WIDTH-1]) ? -b : b;
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opd_q};
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    // Next-state and register update logic for the IDLE/CALC/FIX sequence and MTHI/MTLO writes.
    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        dz_d       = dz_q;
        acc_d      = acc_q;
        opd_d      = opd_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    is_div_d  = func[1];
                    neg_d     = func[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    rem_neg_d = func[0] & a[WIDTH-1];
                    cnt_d     = '0;
                    if (func[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        opd_d   = mag_b;
                        dz_d    = (b == '0);
                        state_d = (b == '0) ? FIX : CALC;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        opd_d   = mag_a;
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else              acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    if (acc_q[0]) acc_d = {sum, acc_q[WIDTH-1:1]};
                    else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                if (dz_q) begin
                    div_zero_d = 1'b1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                dz_d    = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous reset that also aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            dz_q       <= 1'b0;
            acc_q      <= '0;
            opd_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            dz_q       <= dz_d;
            acc_q      <= acc_d;
            opd_q      <= opd_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors with hand-computed results, checked by a scoreboard monitor on done.
module tb_mul_div_unit;

    localparam logic [1:0] MULTU = 2'b00;
    localparam logic [1:0] MULT  = 2'b01;
    localparam logic [1:0] DIVU  = 2'b10;
    localparam logic [1:0] DIV   = 2'b11;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  func;
    logic [31:0] a, b;
    logic        hi_we, lo_we;
    logic [31:0] wdata;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n;

    mul_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .func(func), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Safety net so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_hi", hi, e.hi);
                checkOutput("sb_lo", lo, e.lo);
                checkOutput("sb_div_zero", div_zero, e.dz);
            end
        end
    end

    task automatic pushExp(input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        sb.push_back(e);
    endtask

    // Present one start cycle, optionally with a simultaneous MTHI; operands are scrambled afterwards.
    task automatic issueStart(input logic [1:0] f, input logic [31:0] av, input logic [31:0] bv,
                              input logic with_write);
        @(negedge clk);
        func  = f;
        a     = av;
        b     = bv;
        start = 1'b1;
        hi_we = with_write;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        func  = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    // Count busy cycles from the current negedge until busy drops, bounded.
    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] f, input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                                 input int ebusy, input logic with_write);
        int cyc;
        pushExp(ehi, elo, edz);
        issueStart(f, av, bv, with_write);
        waitIdle(cyc);
        checkOutput("busy_cycles", 64'(cyc), 64'(ebusy));
        checkOutput("done_high", done, 1);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 0);
        checkOutput("div_zero_one_cycle", div_zero, 0);
    endtask

    task automatic mtWrite(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        hi_we = whi;
        lo_we = wlo;
        wdata = d;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; func = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_div_zero", div_zero, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        rst = 1'b0;

        applyStimulus(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b0);
        applyStimulus(MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 1'b0);
        applyStimulus(DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
        applyStimulus(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33, 1'b0);

        mtWrite(1'b1, 1'b0, 32'h0000_1234);
        checkOutput("mthi_hi", hi, 32'h0000_1234);
        checkOutput("mthi_lo_kept", lo, 32'd14);
        mtWrite(1'b0, 1'b1, 32'h0000_5678);
        checkOutput("mtlo_lo", lo, 32'h0000_5678);
        checkOutput("mtlo_hi_kept", hi, 32'h0000_1234);
        applyStimulus(DIVU, 32'd5, 32'd0, 32'h0000_1234, 32'h0000_5678, 1'b1, 1, 1'b0);

        mtWrite(1'b1, 1'b1, 32'hAAAA_5555);
        checkOutput("mt_both_hi", hi, 32'hAAAA_5555);
        checkOutput("mt_both_lo", lo, 32'hAAAA_5555);

        // start and MTHI in the same cycle: divide-by-zero keeps HI, so a leaked write would show.
        applyStimulus(DIVU, 32'd9, 32'd0, 32'hAAAA_5555, 32'hAAAA_5555, 1'b1, 1, 1'b1);

        applyStimulus(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 33, 1'b0);

        // Disturbed MULTU: a second start plus MT writes mid-operation must be ignored.
        pushExp(32'h0000_0001, 32'h2345_0000, 1'b0);
        issueStart(MULTU, 32'h0001_2345, 32'h0001_0000, 1'b0);
        repeat (8) @(negedge clk);
        start = 1'b1; func = DIVU; a = 32'd1; b = 32'd1;
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_0BAD;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        checkOutput("calc_hi_stable", hi, 32'h0000_0000);
        checkOutput("calc_lo_stable", lo, 32'h8000_0000);
        waitIdle(n);
        checkOutput("disturbed_busy_cycles", 64'(n), 64'd24);
        checkOutput("disturbed_done", done, 1);
        @(negedge clk);
        checkOutput("disturbed_no_second_op", busy, 0);

        // Back-to-back: start again in the done cycle.
        pushExp(32'd0, 32'd42, 1'b0);
        issueStart(MULTU, 32'd6, 32'd7, 1'b0);
        waitIdle(n);
        checkOutput("b2b_first_busy", 64'(n), 64'd33);
        pushExp(32'd2, 32'd6, 1'b0);
        start = 1'b1; func = DIVU; a = 32'd50; b = 32'd8;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b_busy_again", busy, 1);
        checkOutput("b2b_done_low", done, 0);
        waitIdle(n);
        checkOutput("b2b_second_busy", 64'(n), 64'd33);
        @(negedge clk);

        // Reset in the middle of a DIV discards the operation and clears HI/LO.
        issueStart(DIV, 32'hFFFF_FF00, 32'd3, 1'b0);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_hi", hi, 0);
        checkOutput("midrst_lo", lo, 0);
        rst = 1'b0;
        applyStimulus(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 1'b0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit in the EX stage of the MIPS core. It sits beside the 32-bit ALU adder and shares its operand buses.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles and holds the HI/LO registers.
- Serves MFHI/MFLO reads and MTHI/MTLO writes.
- Its stall output freezes the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration-counter width; must hold the value WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- func  input  2  bit0 = signed, bit1 = divide: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV (same sign/sub bit placement as the ALU adder func)
- a  input  WIDTH  multiplicand / dividend (rs)
- b  input  WIDTH  multiplier / divisor (rt)
- hi_we  input  1  MTHI: write wdata into HI
- lo_we  input  1  MTLO: write wdata into LO
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  operation in flight; pipeline stall request
- done  output  1  one-cycle pulse when HI/LO hold a new result
- div_zero  output  1  one-cycle pulse, coincident with done, on division by zero
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0; counter and working registers cleared. Reset mid-operation aborts the operation and discards any partial result.
- States: IDLE, CALC, FIX.
- IDLE + start=1 at edge E0:
  - latch func; for signed ops latch |a| and |b| plus the result signs; clear the 2*WIDTH accumulator; counter=0; busy=1.
  - Next state CALC. Divide with b==0 goes to FIX directly.
- CALC, one bit per cycle, WIDTH cycles (E1..E32):
  - Multiply is shift-add. If the multiplier LSB=1, add the multiplicand into the upper half with a WIDTH+1-bit sum. Shift right by 1.
  - Divide is restoring. Shift the remainder:quotient left by 1, then trial-subtract the divisor using a WIDTH+1-bit difference. If non-negative, keep the difference and set the quotient LSB to 1.
  - When the counter reaches WIDTH-1, go to FIX.
- FIX (edge E33):
  - Apply sign correction (two's-complement negate).
  - MULT: negate the 64-bit product when the operand signs differ.
  - DIV: the quotient takes sign a^b; the remainder takes the sign of a.
  - Write HI/LO: multiply gives HI=product[63:32], LO=product[31:0]; divide gives HI=remainder, LO=quotient.
  - done=1 and busy=0 for the cycle after E33; return to IDLE.
- Latency: result is visible in hi/lo, with done high, 33 cycles after the start edge. busy is high for exactly 33 cycles.
- Division by zero: skip CALC; at the next edge go FIX→IDLE. hi/lo are unchanged; done=1 and div_zero=1 for one cycle; busy is high for 1 cycle only.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. This is the natural result of the magnitude path; no flag is raised.
- start while busy is ignored; no queueing.
- func/a/b changes after E0 have no effect.
- hi_we/lo_we are honoured only in IDLE with start=0.
  - start and hi_we in the same IDLE cycle: start wins and the write is dropped.
  - hi_we and lo_we together write both registers.
  - Writes during busy are ignored; the decoder stalls them.
- done and div_zero are never high for more than one consecutive cycle. Back-to-back start in the done cycle is accepted.
- hi/lo are stable throughout CALC and change only at the FIX edge, an MT write, or reset.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, done pulse of 1 cycle, busy high 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=-7 (0xFFFFFFF9), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=7 → LO=14, HI=2. Then DIVU b=0 with HI/LO preset via MTHI=0x1234 and MTLO=0x5678 → done and div_zero pulse 1 cycle after start, HI/LO unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, div_zero=0.
- start pulsed again at cycle 10 of a MULTU, and hi_we=1 mid-operation → both ignored, result identical to an undisturbed run. start in the done cycle → second operation begins, busy returns high next cycle.
- rst asserted at cycle 20 of a DIV → next cycle busy=0, done=0, hi=lo=0. A fresh MULTU 3*5 then gives LO=15, HI=0.
